// File: rtl/pin_entry_verifier.sv
// PIN entry stage: assembles BCD keypad digits, compares them with the stored PIN and tracks failed
// attempts up to lockout. Define PIN_TIMEOUT_EN to build the inter-digit timeout counter.
module pin_entry_verifier #(
  parameter int NUM_DIGITS     = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             tarjeta_recibida,
  input  logic                             cancelar,
  input  logic                             digito_stb,
  input  logic [3:0]                       digito,
  input  logic [4*NUM_DIGITS-1:0]          pin,
  output logic [$clog2(NUM_DIGITS+1)-1:0]  digit_count,
  output logic                             busy,
  output logic                             pin_ok,
  output logic                             pin_incorrecto,
  output logic                             advertencia,
  output logic                             bloqueo,
  output logic                             timeout
);

  localparam int PinW  = 4 * NUM_DIGITS;
  localparam int CntW  = $clog2(NUM_DIGITS + 1);
  localparam int FailW = $clog2(MAX_ATTEMPTS + 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CHECK,
    LOCKED
  } state_t;

  state_t            state_q, state_d;
  logic [PinW-1:0]   entered_q, entered_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [FailW-1:0]  fails_q, fails_d;
  logic [FailW-1:0]  fails_inc;
  logic              warn_q, warn_d;
  logic              res_ok_q, res_ok_d;
  logic              res_bad_q, res_bad_d;
  logic              digit_valid;
  logic              timer_fire;

  assign digit_valid = digito_stb && (digito <= 4'd9);
  assign fails_inc   = fails_q + FailW'(1);
  assign digit_count = count_q;

`ifdef PIN_TIMEOUT_EN
  localparam int TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  logic [TimerW-1:0] timer_q, timer_d;

  // The timer saturates while no digit is pending; the first accepted digit restarts it.
  always_comb begin
    timer_fire = (state_q == COLLECT) && !cancelar && !digit_valid &&
                 (count_q != '0) && (timer_q == TimerLast);
    timer_d    = timer_q;
    if (state_q != COLLECT || digit_valid || timer_fire) begin
      timer_d = '0;
    end else if (timer_q != TimerLast) begin
      timer_d = timer_q + TimerW'(1);
    end
  end
`else
  assign timer_fire = 1'b0;
  // Constant 0; TIMEOUT_CYCLES only matters when the timer is built.
  assign timeout    = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    entered_d = entered_q;
    count_d   = count_q;
    fails_d   = fails_q;
    warn_d    = warn_q;
    res_ok_d  = 1'b0;
    res_bad_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tarjeta_recibida) begin
          state_d   = COLLECT;
          entered_d = '0;
          count_d   = '0;
          fails_d   = '0;
          warn_d    = 1'b0;
        end
      end

      COLLECT: begin
        if (cancelar) begin
          state_d   = IDLE;
          entered_d = '0;
          count_d   = '0;
          fails_d   = '0;
          warn_d    = 1'b0;
        end else if (digit_valid) begin
          entered_d = {entered_q[PinW-5:0], digito};
          count_d   = count_q + CntW'(1);
          if (count_q == CntW'(NUM_DIGITS - 1)) state_d = CHECK;
        end else if (timer_fire) begin
          entered_d = '0;
          count_d   = '0;
        end
      end

      CHECK: begin
        if (entered_q == pin) begin
          res_ok_d = 1'b1;
          fails_d  = '0;
          warn_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          res_bad_d = 1'b1;
          fails_d   = fails_inc;
          entered_d = '0;
          count_d   = '0;
          if (fails_inc == FailW'(MAX_ATTEMPTS)) begin
            warn_d  = 1'b0;
            state_d = LOCKED;
          end else begin
            if (fails_inc == FailW'(MAX_ATTEMPTS - 1)) warn_d = 1'b1;
            state_d = COLLECT;
          end
        end
      end

      LOCKED: state_d = LOCKED;

      default: state_d = IDLE;
    endcase
  end

  // Result pulses and the warning/lock levels leave through one more register stage so they appear
  // together, two edges after the final digit.
  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clock) begin
    // NOTE: the PIN datapath is reset together with control; a stale entry must never be compared.
    if (reset) begin
      state_q        <= IDLE;
      entered_q      <= '0;
      count_q        <= '0;
      fails_q        <= '0;
      warn_q         <= 1'b0;
      res_ok_q       <= 1'b0;
      res_bad_q      <= 1'b0;
      busy           <= 1'b0;
      pin_ok         <= 1'b0;
      pin_incorrecto <= 1'b0;
      advertencia    <= 1'b0;
      bloqueo        <= 1'b0;
`ifdef PIN_TIMEOUT_EN
      timer_q        <= '0;
      timeout        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      entered_q      <= entered_d;
      count_q        <= count_d;
      fails_q        <= fails_d;
      warn_q         <= warn_d;
      res_ok_q       <= res_ok_d;
      res_bad_q      <= res_bad_d;
      busy           <= (state_d == COLLECT) || (state_d == CHECK);
      pin_ok         <= res_ok_q;
      pin_incorrecto <= res_bad_q;
      advertencia    <= warn_q;
      bloqueo        <= (state_q == LOCKED);
`ifdef PIN_TIMEOUT_EN
      timer_q        <= timer_d;
      timeout        <= timer_fire;
`endif
    end
  end

endmodule

// File: tb/tb_pin_entry_verifier.sv
// Self-checking bench for pin_entry_verifier: directed scenarios plus randomized entries scored
// against an attempt-level reference model.
module tb_pin_entry_verifier;

  localparam int ND = 4;
  localparam int MA = 3;
`ifdef PIN_TIMEOUT_EN
  localparam int TC = 8;
`else
  localparam int TC = 1024;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        tarjeta_recibida;
  logic        cancelar;
  logic        digito_stb;
  logic [3:0]  digito;
  logic [15:0] pin;
  logic [2:0]  digit_count;
  logic        busy, pin_ok, pin_incorrecto, advertencia, bloqueo, timeout;

  int checks = 0;
  int errors = 0;

  // Reference model: attempt-level bookkeeping only.
  int m_count;
  int m_fails;
  bit m_warn;
  bit m_locked;
  bit m_in_entry;

  pin_entry_verifier #(
    .NUM_DIGITS(ND),
    .MAX_ATTEMPTS(MA),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .tarjeta_recibida(tarjeta_recibida),
    .cancelar(cancelar),
    .digito_stb(digito_stb),
    .digito(digito),
    .pin(pin),
    .digit_count(digit_count),
    .busy(busy),
    .pin_ok(pin_ok),
    .pin_incorrecto(pin_incorrecto),
    .advertencia(advertencia),
    .bloqueo(bloqueo),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    m_count    = 0;
    m_fails    = 0;
    m_warn     = 1'b0;
    m_locked   = 1'b0;
    m_in_entry = 1'b0;
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    tarjeta_recibida = 1'b0;
    cancelar         = 1'b0;
    digito_stb       = 1'b0;
    digito           = 4'd0;
    step();
    step();
    reset = 1'b0;
    model_clear();
  endtask

  task automatic start_card();
    tarjeta_recibida = 1'b1;
    digito_stb       = 1'b1;
    digito           = 4'd5;
    step();
    tarjeta_recibida = 1'b0;
    digito_stb       = 1'b0;
    m_count    = 0;
    m_fails    = 0;
    m_warn     = 1'b0;
    m_in_entry = 1'b1;
    checks++;
    if (digit_count !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL card_start: digit_count=%0d busy=%b, expected 0 and 1", digit_count, busy);
    end
  endtask

  task automatic send_digit(input logic [3:0] d);
    digito     = d;
    digito_stb = 1'b1;
    step();
    digito_stb = 1'b0;
    digito     = 4'($urandom);
    if (d <= 4'd9) m_count++;
    checks++;
    if (digit_count !== 3'(m_count)) begin
      errors++;
      $display("FAIL digit_count: got %0d expected %0d after digit %h", digit_count, m_count, d);
    end
  endtask

  // Called right after the final digit was sampled; walks the three following edges.
  task automatic resolve(input logic [15:0] ent);
    bit exp_ok;
    exp_ok = (ent == pin);
    cancelar         = 1'($urandom_range(0, 1));
    digito_stb       = 1'($urandom_range(0, 1));
    digito           = 4'($urandom_range(0, 9));
    step();
    cancelar   = 1'b0;
    digito_stb = 1'b0;
    checks++;
    if (pin_ok !== 1'b0 || pin_incorrecto !== 1'b0) begin
      errors++;
      $display("FAIL early_pulse: pin_ok=%b pin_incorrecto=%b one edge after last digit", pin_ok, pin_incorrecto);
    end
    step();
    if (exp_ok) begin
      m_fails = 0;
      m_warn  = 1'b0;
    end else begin
      m_fails++;
      if (m_fails == MA) begin
        m_locked = 1'b1;
        m_warn   = 1'b0;
      end else if (m_fails == MA - 1) begin
        m_warn = 1'b1;
      end
    end
    m_in_entry = !exp_ok && !m_locked;
    m_count    = 0;
    checks++;
    if (pin_ok !== exp_ok || pin_incorrecto !== !exp_ok) begin
      errors++;
      $display("FAIL result_pulse: entry %h pin %h got ok=%b bad=%b expected ok=%b", ent, pin, pin_ok, pin_incorrecto, exp_ok);
    end
    checks++;
    if (advertencia !== m_warn || bloqueo !== m_locked) begin
      errors++;
      $display("FAIL levels: advertencia=%b bloqueo=%b expected %b %b", advertencia, bloqueo, m_warn, m_locked);
    end
    step();
    checks++;
    if (pin_ok !== 1'b0 || pin_incorrecto !== 1'b0 || busy !== m_in_entry) begin
      errors++;
      $display("FAIL pulse_end: ok=%b bad=%b busy=%b expected 0 0 %b", pin_ok, pin_incorrecto, busy, m_in_entry);
    end
  endtask

  task automatic enter(input logic [15:0] ent);
    for (int i = ND - 1; i >= 0; i--) send_digit(ent[4*i +: 4]);
    resolve(ent);
  endtask

  task automatic do_cancel(input bit with_digit);
    cancelar   = 1'b1;
    digito_stb = with_digit;
    digito     = 4'd3;
    step();
    cancelar   = 1'b0;
    digito_stb = 1'b0;
    m_count    = 0;
    m_fails    = 0;
    m_warn     = 1'b0;
    m_in_entry = 1'b0;
    checks++;
    if (digit_count !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_state: digit_count=%0d busy=%b expected 0 0", digit_count, busy);
    end
    step();
    checks++;
    if (advertencia !== 1'b0 || pin_ok !== 1'b0 || pin_incorrecto !== 1'b0) begin
      errors++;
      $display("FAIL cancel_outputs: adv=%b ok=%b bad=%b expected all 0", advertencia, pin_ok, pin_incorrecto);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({digit_count, busy, pin_ok, pin_incorrecto, advertencia, bloqueo, timeout} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: cnt=%0d busy=%b ok=%b bad=%b adv=%b blk=%b tmo=%b expected all 0",
               digit_count, busy, pin_ok, pin_incorrecto, advertencia, bloqueo, timeout);
    end
  endtask

  task automatic test_match();
    pin = 16'h1234;
    start_card();
    enter(16'h1234);
  endtask

  task automatic test_warning();
    pin = 16'h1234;
    start_card();
    enter(16'h1235);
    enter(16'h1235);
    enter(16'h1234);
  endtask

  task automatic test_lockout();
    do_reset();
    pin = 16'h1234;
    start_card();
    enter(16'h9999);
    enter(16'h9999);
    enter(16'h9999);
    for (int k = 0; k < 12; k++) begin
      tarjeta_recibida = 1'($urandom_range(0, 1));
      cancelar         = 1'($urandom_range(0, 1));
      digito_stb       = 1'b1;
      digito           = 4'($urandom_range(0, 9));
      step();
      checks++;
      if (pin_ok !== 1'b0 || pin_incorrecto !== 1'b0 || bloqueo !== 1'b1 || busy !== 1'b0 || digit_count !== 3'd0) begin
        errors++;
        $display("FAIL locked_hold: ok=%b bad=%b blk=%b busy=%b cnt=%0d expected 0 0 1 0 0",
                 pin_ok, pin_incorrecto, bloqueo, busy, digit_count);
      end
    end
    tarjeta_recibida = 1'b0;
    cancelar         = 1'b0;
    digito_stb       = 1'b0;
    do_reset();
    checks++;
    if (bloqueo !== 1'b0) begin
      errors++;
      $display("FAIL lock_release: bloqueo=%b expected 0 after reset", bloqueo);
    end
  endtask

  task automatic test_invalid_digit();
    pin = 16'h1234;
    start_card();
    send_digit(4'h1);
    send_digit(4'h2);
    send_digit(4'hB);
    send_digit(4'h3);
    send_digit(4'h4);
    resolve(16'h1234);
  endtask

  task automatic test_cancel();
    pin = 16'h1234;
    start_card();
    send_digit(4'h1);
    send_digit(4'h2);
    do_cancel(1'b1);
    start_card();
    enter(16'h1234);
    // Cancel must drop the warning and forget previous failures.
    start_card();
    enter(16'h1235);
    enter(16'h1235);
    send_digit(4'h1);
    do_cancel(1'b0);
    start_card();
    enter(16'h1235);
    enter(16'h1234);
  endtask

  task automatic test_reset_mid_entry();
    pin = 16'h1234;
    start_card();
    send_digit(4'h1);
    send_digit(4'h2);
    do_reset();
    start_card();
    for (int i = ND - 1; i >= 0; i--) send_digit(pin[4*i +: 4]);
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_clear();
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (pin_ok !== 1'b0 || pin_incorrecto !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_abort: ok=%b bad=%b busy=%b expected 0 0 0", pin_ok, pin_incorrecto, busy);
      end
    end
  endtask

  task automatic test_timeout();
    int seen;
    int first_at;
    pin = 16'h1234;
    start_card();
    send_digit(4'h1);
    send_digit(4'h2);
    seen     = 0;
    first_at = -1;
`ifdef PIN_TIMEOUT_EN
    for (int k = 1; k <= 12; k++) begin
      step();
      if (timeout === 1'b1) begin
        if (seen == 0) first_at = k;
        seen++;
      end
    end
    m_count = 0;
    checks++;
    if (seen != 1 || first_at != TC || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL timeout_pulse: pulses=%0d first_at=%0d cnt=%0d expected 1 %0d 0", seen, first_at, digit_count, TC);
    end
    enter(16'h1234);
`else
    for (int k = 1; k <= 40; k++) begin
      step();
      if (timeout !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || digit_count !== 3'd2) begin
      errors++;
      $display("FAIL no_timeout: timeout cycles=%0d cnt=%0d expected 0 2", seen, digit_count);
    end
    do_cancel(1'b0);
`endif
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < ND; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic test_random();
    logic [15:0] target;
    logic [15:0] ent;
    bit aborted;
    for (int it = 0; it < 60; it++) begin
      if (m_locked) do_reset();
      if (!m_in_entry) start_card();
      target  = rand_bcd();
      ent     = ($urandom_range(0, 2) == 0) ? target : rand_bcd();
      aborted = 1'b0;
      for (int i = ND - 1; i >= 0; i--) begin
        if ($urandom_range(0, 3) == 0) send_digit(4'($urandom_range(10, 15)));
        if ($urandom_range(0, 24) == 0) begin
          do_cancel(1'($urandom_range(0, 1)));
          aborted = 1'b1;
          break;
        end
        pin = 16'($urandom);
        send_digit(ent[4*i +: 4]);
      end
      if (!aborted) begin
        pin = target;
        resolve(ent);
      end
    end
  endtask

  initial begin
    reset            = 1'b1;
    tarjeta_recibida = 1'b0;
    cancelar         = 1'b0;
    digito_stb       = 1'b0;
    digito           = 4'd0;
    pin              = 16'h1234;
    model_clear();
    test_reset();
    test_match();
    test_warning();
    test_lockout();
    test_invalid_digit();
    test_cancel();
    test_reset_mid_entry();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
